// File: rtl/sram_ctrl_ws_if.sv
// Request/response bus between the system arbiter and the SRAM controller.
// The arbiter side is the master; the controller is the slave.
interface sram_ctrl_ws_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8
);
    logic              iRd;
    logic              iWr;
    logic [ADDR_W-1:0] iAddr;
    logic [DATA_W-1:0] iWData;
    logic              oReady;
    logic [DATA_W-1:0] oRData;
    logic              oRValid;

    modport master (
        output iRd, iWr, iAddr, iWData,
        input  oReady, oRData, oRValid
    );

    modport slave (
        input  iRd, iWr, iAddr, iWData,
        output oReady, oRData, oRValid
    );
endinterface

// File: rtl/sram_ctrl_ws.sv
// Asynchronous SRAM controller: latched request, programmable read/write wait
// states, turnaround idle cycles on read<->write switches, registered strobes.
//
// state | meaning
// IDLE  | strobes off, oReady=1, accepts a request
// TURN  | chip selected, OE/WE off, bus released before changing direction
// RD    | OE low for RD_WAIT+1 cycles, data captured on the last one
// WR    | WE low for WR_WAIT+1 cycles, pads driven
// HOLD  | WE released, pads still driven for data/address hold
module sram_ctrl_ws #(
    parameter int ADDR_W  = 19,
    parameter int DATA_W  = 8,
    parameter int RD_WAIT = 1,
    parameter int WR_WAIT = 1,
    parameter int TURN    = 1
) (
    input  logic              iClk,
    input  logic              iRst,
    sram_ctrl_ws_if.slave     bus,
    output logic [ADDR_W-1:0] oSramAddr,
    output logic [DATA_W-1:0] oSramDout,
    input  logic [DATA_W-1:0] iSramDin,
    output logic              oDir,
    output logic              oCe1,
    output logic              oCe2,
    output logic              oOe,
    output logic              oWe
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TURN,
        S_RD,
        S_WR,
        S_HOLD
    } state_t;

    localparam bit       TURN_EN = (TURN > 0);
    localparam logic [3:0] RD_LD   = 4'(RD_WAIT);
    localparam logic [3:0] WR_LD   = 4'(WR_WAIT);
    localparam logic [3:0] TURN_LD = TURN_EN ? 4'(TURN - 1) : 4'd0;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              last_wr_q, last_wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              dir_q, dir_d;
    logic              ce1_q, ce1_d;
    logic              oe_q, oe_d;
    logic              we_q, we_d;
    logic              req_wr;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            last_wr_q <= 1'b0;
            addr_q    <= '0;
            dout_q    <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            dir_q     <= 1'b0;
            ce1_q     <= 1'b1;
            oe_q      <= 1'b1;
            we_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_wr_q <= last_wr_d;
            addr_q    <= addr_d;
            dout_q    <= dout_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            dir_q     <= dir_d;
            ce1_q     <= ce1_d;
            oe_q      <= oe_d;
            we_q      <= we_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_wr_d = last_wr_q;
        addr_d    = addr_q;
        dout_d    = dout_q;
        rdata_d   = rdata_q;
        rvalid_d  = 1'b0;
        req_wr    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.iRd || bus.iWr) begin
                    // Read has priority; a simultaneous write is discarded.
                    req_wr    = !bus.iRd;
                    addr_d    = bus.iAddr;
                    dout_d    = bus.iWData;
                    last_wr_d = req_wr;
                    if (TURN_EN && (req_wr != last_wr_q)) begin
                        state_d = S_TURN;
                        cnt_d   = TURN_LD;
                    end else if (req_wr) begin
                        state_d = S_WR;
                        cnt_d   = WR_LD;
                    end else begin
                        state_d = S_RD;
                        cnt_d   = RD_LD;
                    end
                end
            end
            S_TURN: begin
                if (cnt_q == 4'd0) begin
                    // last_wr_q already holds the type of the pending access.
                    if (last_wr_q) begin
                        state_d = S_WR;
                        cnt_d   = WR_LD;
                    end else begin
                        state_d = S_RD;
                        cnt_d   = RD_LD;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RD: begin
                if (cnt_q == 4'd0) begin
                    rdata_d  = iSramDin;
                    rvalid_d = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_WR: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_HOLD: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Strobes are registered from the next state so they line up with it.
        ce1_d = (state_d == S_IDLE);
        oe_d  = (state_d != S_RD);
        we_d  = (state_d != S_WR);
        dir_d = (state_d == S_WR) || (state_d == S_HOLD);
    end

    assign bus.oReady  = (state_q == S_IDLE);
    assign bus.oRData  = rdata_q;
    assign bus.oRValid = rvalid_q;

    assign oSramAddr = addr_q;
    assign oSramDout = dout_q;
    assign oDir      = dir_q;
    assign oCe1      = ce1_q;
    assign oCe2      = 1'b1;
    assign oOe       = oe_q;
    assign oWe       = we_q;

endmodule

// File: tb/tb_sram_ctrl_ws.sv
// Directed bench for sram_ctrl_ws: one instance with default timing, one with
// RD_WAIT=3/WR_WAIT=0/TURN=2, each attached to a small SRAM model.
module tb_sram_ctrl_ws;

    logic iClk = 1'b0;
    always #5 iClk = ~iClk;

    logic rst0, rst1;

    sram_ctrl_ws_if #(.ADDR_W(19), .DATA_W(8)) bus0 ();
    sram_ctrl_ws_if #(.ADDR_W(19), .DATA_W(8)) bus1 ();

    logic [18:0] addr0, addr1;
    logic [7:0]  dout0, dout1, din0, din1;
    logic        dir0, ce1_0, ce2_0, oe0, we0;
    logic        dir1, ce1_1, ce2_1, oe1, we1;

    sram_ctrl_ws u0 (
        .iClk      (iClk),
        .iRst      (rst0),
        .bus       (bus0),
        .oSramAddr (addr0),
        .oSramDout (dout0),
        .iSramDin  (din0),
        .oDir      (dir0),
        .oCe1      (ce1_0),
        .oCe2      (ce2_0),
        .oOe       (oe0),
        .oWe       (we0)
    );

    sram_ctrl_ws #(.RD_WAIT(3), .WR_WAIT(0), .TURN(2)) u1 (
        .iClk      (iClk),
        .iRst      (rst1),
        .bus       (bus1),
        .oSramAddr (addr1),
        .oSramDout (dout1),
        .iSramDin  (din1),
        .oDir      (dir1),
        .oCe1      (ce1_1),
        .oCe2      (ce2_1),
        .oOe       (oe1),
        .oWe       (we1)
    );

    // SRAM models, indexed by the low address byte.
    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    logic       pre_we0;
    logic [7:0] pre_a0, pre_d0;

    always @(posedge iClk) begin
        if (!ce1_0 && !we0) mem0[addr0[7:0]] <= dout0;
        else if (pre_we0)   mem0[pre_a0]     <= pre_d0;
    end
    always @(posedge iClk) begin
        if (!ce1_1 && !we1) mem1[addr1[7:0]] <= dout1;
    end
    assign din0 = mem0[addr0[7:0]];
    assign din1 = mem1[addr1[7:0]];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    // Pad-contention invariant on both instances.
    always @(negedge iClk) begin
        chk("dir_oe_excl_u0", {31'd0, dir0 & ~oe0}, 32'd0);
        chk("dir_oe_excl_u1", {31'd0, dir1 & ~oe1}, 32'd0);
    end

    task automatic preload0(input logic [7:0] a, input logic [7:0] d);
        pre_a0  = a;
        pre_d0  = d;
        pre_we0 = 1'b1;
        tick();
        pre_we0 = 1'b0;
    endtask

    task automatic wr1(input logic [18:0] a, input logic [7:0] d, input int exp_lat);
        int n;
        chk("wr1_ready_pre", bus1.oReady, 1);
        bus1.iWr    = 1'b1;
        bus1.iAddr  = a;
        bus1.iWData = d;
        tick();
        bus1.iWr = 1'b0;
        n = 1;
        while (!bus1.oReady && n < 50) begin
            tick();
            n++;
        end
        chk("wr1_occupancy", n, exp_lat);
        chk("wr1_mem", mem1[a[7:0]], d);
    endtask

    task automatic rd1(input logic [18:0] a, input logic [7:0] d, input int exp_lat);
        int n;
        chk("rd1_ready_pre", bus1.oReady, 1);
        bus1.iRd   = 1'b1;
        bus1.iAddr = a;
        tick();
        bus1.iRd = 1'b0;
        n = 1;
        while (!bus1.oRValid && n < 50) begin
            tick();
            n++;
        end
        chk("rd1_latency", n, exp_lat);
        chk("rd1_data", bus1.oRData, d);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [18:0] a;
        logic [7:0]  d;

        rst0 = 1'b1; rst1 = 1'b1; pre_we0 = 1'b0; pre_a0 = '0; pre_d0 = '0;
        bus0.iRd = 1'b0; bus0.iWr = 1'b0; bus0.iAddr = '0; bus0.iWData = '0;
        bus1.iRd = 1'b0; bus1.iWr = 1'b0; bus1.iAddr = '0; bus1.iWData = '0;
        repeat (3) tick();
        rst0 = 1'b0; rst1 = 1'b0;

        // Reset state held through 5 idle cycles.
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_oe", oe0, 1);
            chk("idle_we", we0, 1);
            chk("idle_ce1", ce1_0, 1);
            chk("idle_ce2", ce2_0, 1);
            chk("idle_dir", dir0, 0);
            chk("idle_ready", bus0.oReady, 1);
            chk("idle_rvalid", bus0.oRValid, 0);
        end
        chk("rst_addr", addr0, 0);
        chk("rst_dout", dout0, 0);
        chk("rst_rdata", bus0.oRData, 0);

        // Default-timing read of 0x00010, no turnaround.
        preload0(8'h10, 8'hA5);
        bus0.iRd   = 1'b1;
        bus0.iAddr = 19'h00010;
        tick();
        bus0.iRd = 1'b0;
        chk("rd_c1_oe", oe0, 0);
        chk("rd_c1_ce1", ce1_0, 0);
        chk("rd_c1_ready", bus0.oReady, 0);
        chk("rd_c1_addr", addr0, 19'h00010);
        tick();
        chk("rd_c2_oe", oe0, 0);
        chk("rd_c2_rvalid", bus0.oRValid, 0);
        tick();
        chk("rd_c3_oe", oe0, 1);
        chk("rd_c3_rvalid", bus0.oRValid, 1);
        chk("rd_c3_rdata", bus0.oRData, 8'hA5);
        chk("rd_c3_ready", bus0.oReady, 1);
        tick();
        chk("rd_c4_rvalid", bus0.oRValid, 0);

        // Write 0x3C to 0x7FFFF right after reset: one turnaround cycle.
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        bus0.iWr    = 1'b1;
        bus0.iAddr  = 19'h7FFFF;
        bus0.iWData = 8'h3C;
        tick();
        bus0.iWr = 1'b0;
        chk("wr_c1_ce1", ce1_0, 0);
        chk("wr_c1_oe", oe0, 1);
        chk("wr_c1_we", we0, 1);
        chk("wr_c1_dir", dir0, 0);
        chk("wr_c1_ready", bus0.oReady, 0);
        tick();
        chk("wr_c2_we", we0, 0);
        chk("wr_c2_dir", dir0, 1);
        chk("wr_c2_dout", dout0, 8'h3C);
        tick();
        chk("wr_c3_we", we0, 0);
        chk("wr_c3_dir", dir0, 1);
        tick();
        chk("wr_c4_we", we0, 1);
        chk("wr_c4_dir", dir0, 1);
        chk("wr_c4_ce1", ce1_0, 0);
        chk("wr_c4_ready", bus0.oReady, 0);
        chk("wr_c4_addr", addr0, 19'h7FFFF);
        tick();
        chk("wr_c5_ready", bus0.oReady, 1);
        chk("wr_c5_ce1", ce1_0, 1);
        chk("wr_c5_dir", dir0, 0);
        chk("wr_mem", mem0[8'hFF], 8'h3C);

        // Simultaneous read and write: read wins, write is dropped.
        preload0(8'h20, 8'h11);
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        bus0.iRd    = 1'b1;
        bus0.iWr    = 1'b1;
        bus0.iAddr  = 19'h00020;
        bus0.iWData = 8'h99;
        tick();
        bus0.iRd = 1'b0;
        bus0.iWr = 1'b0;
        chk("both_c1_oe", oe0, 0);
        chk("both_c1_we", we0, 1);
        tick();
        chk("both_c2_we", we0, 1);
        tick();
        chk("both_c3_rvalid", bus0.oRValid, 1);
        chk("both_c3_rdata", bus0.oRData, 8'h11);
        chk("both_mem", mem0[8'h20], 8'h11);

        // Alternating W/R on the slow instance: each switch costs TURN=2.
        for (int k = 0; k < 4; k++) begin
            a = 19'h40000 | 19'(k * 3 + 5);
            d = 8'($urandom_range(0, 255));
            wr1(a, d, 5);
            rd1(a, d, 7);
        end

        // Reset during the 2nd RD cycle; last type is read so no turnaround.
        bus1.iRd   = 1'b1;
        bus1.iAddr = 19'h40005;
        tick();
        bus1.iRd = 1'b0;
        tick();
        chk("rstmid_c2_oe", oe1, 0);
        rst1 = 1'b1;
        tick();
        rst1 = 1'b0;
        chk("rstmid_oe", oe1, 1);
        chk("rstmid_ce1", ce1_1, 1);
        chk("rstmid_we", we1, 1);
        chk("rstmid_dir", dir1, 0);
        chk("rstmid_ready", bus1.oReady, 1);
        chk("rstmid_rvalid", bus1.oRValid, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rstmid_no_rvalid", bus1.oRValid, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_ctrl_ws.md
# sram_ctrl_ws

Parametrised asynchronous-SRAM controller with a request/ready handshake, configurable read and write wait states, automatic bus-turnaround insertion and registered SRAM strobes. It sits between the system bus arbiter and the external SRAM pins. It latches address and write data itself and returns read data with a valid pulse, so masters no longer hand-time strobes.

## Interface
- ADDR_W, 19: SRAM address width.
- DATA_W, 8: data width.
- RD_WAIT, 1: extra read cycles with OE asserted (0..15).
- WR_WAIT, 1: extra write cycles with WE asserted (0..15).
- TURN, 1: idle cycles inserted when access type changes (0..3).

- iClk  in  1  system clock; all logic on rising edge.
- iRst  in  1  synchronous, active-high reset.
- iRd  in  1  read request; accepted when oReady=1.
- iWr  in  1  write request; accepted when oReady=1.
- iAddr  in  ADDR_W  request address, sampled on accept.
- iWData  in  DATA_W  write data, sampled on accept.
- oReady  out  1  controller idle, can accept a request this cycle.
- oRData  out  DATA_W  read data, valid while oRValid=1.
- oRValid  out  1  one-cycle pulse per completed read.
- oSramAddr  out  ADDR_W  SRAM address pins.
- oSramDout  out  DATA_W  data driven to SRAM (pad enabled when oDir=1).
- iSramDin  in  DATA_W  data from SRAM pads.
- oDir  out  1  1 = fpga->sram, 0 = fpga<-sram.
- oCe1  out  1  chip enable, active low.
- oCe2  out  1  chip enable, active high; constant 1.
- oOe  out  1  output enable, active low.
- oWe  out  1  write enable, active low.

## Operation
- States: IDLE, TURN, RD, WR, HOLD. All SRAM outputs, oRData and oRValid are registered.
- Accept: in IDLE, when iRd or iWr is high. iRd wins if both are high; the write is dropped, not queued. Accept latches iAddr into oSramAddr and iWData into oSramDout, and records the type in `last`.
- Turnaround: if the accepted type differs from `last`, go to TURN for TURN cycles, otherwise go directly to RD/WR. After reset `last` = read. TURN=0 disables the TURN state.
- TURN: oCe1=0, oOe=1, oWe=1, oDir=0.
- RD: RD_WAIT+1 cycles with oCe1=0, oOe=0, oWe=1, oDir=0. iSramDin is captured into oRData on the last RD cycle; oRValid=1 on the following cycle (in IDLE). Then go to IDLE.
- WR: WR_WAIT+1 cycles with oCe1=0, oWe=0, oOe=1, oDir=1.
- HOLD: 1 cycle with oWe=1, oDir=1, oCe1=0; address and data stay stable for hold time. Then go to IDLE.
- IDLE: oCe1=1, oOe=1, oWe=1, oDir=0. oSramAddr and oSramDout keep their last values.
- oReady = 1 only in IDLE. It is combinational from state, not from iRd/iWr.
- The wait counter is 4 bits. It loads on entry to each timed state and counts down to 0.
- oDir=1 and oOe=0 never occur in the same cycle. This is an invariant.

## Timing
- Reset values: state IDLE, oReady=1, oRValid=0, oRData=0, oSramAddr=0, oSramDout=0, oDir=0, oCe1=1, oCe2=1, oOe=1, oWe=1, `last`=read.
- Reset mid-access: on the next edge all strobes go inactive and oDir=0. A pending oRValid is suppressed.
- Cycle 0 is the accept edge. Without turnaround, strobes are asserted from cycle 1.
- Read latency, accept to oRValid: RD_WAIT+2 cycles, plus TURN if a turnaround was inserted.
- Write occupancy, accept to oReady: WR_WAIT+3 cycles, plus TURN if applicable.
- Back-to-back same-type accesses: a new request is accepted on the oReady cycle. oRValid of the previous read and acceptance of the next read can coincide.
- iRd/iWr held high while busy is ignored. It is accepted again only once oReady=1; masters must deassert after acceptance.

## Test plan
- Reset, then idle 5 cycles -> oOe=1, oWe=1, oCe1=1, oDir=0, oReady=1, oRValid=0 throughout.
- Defaults, read at 0x00010 after reset, SRAM model returns 0xA5 -> oOe low cycles 1-2, oRValid=1 with oRData=0xA5 at cycle 3, no TURN.
- Write 0x3C to 0x7FFFF after reset -> TURN cycle 1 with all strobes high and oDir=0; oWe low cycles 2-3 with oDir=1; HOLD cycle 4; oReady at cycle 5; model holds 0x3C.
- iRd and iWr both high in IDLE -> read performed, write dropped, SRAM contents unchanged.
- RD_WAIT=3, WR_WAIT=0, TURN=2; alternate W/R/W/R with random data -> readback matches each time; oDir=1 and oOe=0 never coincide (assertion).
- iRst asserted during the 2nd RD cycle -> next edge: oOe=1, oCe1=1, oReady=1, and no oRValid pulse.
